vote_ctrl: RTL and testbench

- Sequencer and hazard guard for the vote accumulation buffer.
- It clears the used vote BRAM region, then admits per-tree accumulation results from the tree engine without corrupting the classification label scan or the read-modify-write pipeline.
- It drains the pipeline, then hands the BRAM read port to the PS and signals completion.
- It sits between the tree-engine result stream, the PS control registers and the vote buffer.

---
 rtl/vote_ctrl.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_vote_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vote_ctrl
// Purpose  : Sequencer and hazard guard for the vote accumulation buffer.
//            Clears the used vote BRAM region, admits tree-engine results
//            while protecting the label scan and the read-modify-write
//            pipeline, drains, then hands the BRAM read port to the PS.
// Revision : 1.0 - initial release
// ============================================================================
module vote_ctrl #(
    parameter int N_LABELS_WIDTH = 4,
    parameter int BRAM_AWIDTH    = 14,
    parameter int BRAM_DWIDTH    = 16,
    parameter int RESULTS_WIDTH  = 20,
    parameter int RMW_GAP        = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic                      i_is_clf,
    input  logic [N_LABELS_WIDTH-1:0] i_n_labels,
    input  logic [BRAM_AWIDTH-1:0]    i_n_samples,
    input  logic [RESULTS_WIDTH-1:0]  i_n_results,
    input  logic                      i_res_vld,
    input  logic [BRAM_AWIDTH-1:0]    i_res_slot,
    output logic                      o_res_rdy,
    output logic                      o_accum_vld,
    output logic [BRAM_AWIDTH-1:0]    o_vote_slot,
    output logic                      o_is_clf,
    output logic [N_LABELS_WIDTH-1:0] o_n_labels,
    output logic                      o_is_ps_read,
    output logic                      o_clear_we,
    output logic [BRAM_AWIDTH-1:0]    o_clear_addr,
    output logic [BRAM_DWIDTH-1:0]    o_clear_din,
    input  logic                      i_ps_read_done,
    output logic                      o_busy,
    output logic                      o_done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PROD_W  = BRAM_AWIDTH + N_LABELS_WIDTH;
    localparam int c_SCAN_W  = N_LABELS_WIDTH + 1;
    localparam int c_DRAIN_W = $clog2(RMW_GAP + 1);

    localparam logic [c_PROD_W-1:0]  c_CLEAR_MAX  = c_PROD_W'({BRAM_AWIDTH{1'b1}});
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(RMW_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ACCUM   = 3'd2,
        S_DRAIN   = 3'd3,
        S_PS_READ = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t                    r_state;
    state_t                    w_next_state;

    logic                      r_is_clf;
    logic [N_LABELS_WIDTH-1:0] r_n_labels;
    logic [BRAM_AWIDTH-1:0]    r_n_samples;
    logic [RESULTS_WIDTH-1:0]  r_n_results;

    logic [c_PROD_W-1:0]       w_samples_ext;
    logic [c_PROD_W-1:0]       w_labels_ext;
    logic [c_PROD_W-1:0]       w_prod;
    logic [BRAM_AWIDTH-1:0]    w_clear_len;
    logic [BRAM_AWIDTH-1:0]    w_clear_last_addr;
    logic                      w_clr_last;
    logic                      w_clear_we;
    logic [BRAM_AWIDTH-1:0]    r_clr_addr;

    logic [RESULTS_WIDTH-1:0]  r_acc_cnt;
    logic                      w_acc_room;
    logic                      w_res_rdy;
    logic                      w_accept;

    logic [c_SCAN_W-1:0]       r_scan_cnt;
    logic                      w_scan_busy;

    logic [RMW_GAP-1:0]        r_hist_vld;
    logic [BRAM_AWIDTH-1:0]    r_hist_slot [RMW_GAP];
    logic [RMW_GAP-1:0]        w_match;
    logic                      w_hazard;
    logic                      w_quiet;

    logic [c_DRAIN_W-1:0]      r_drain_cnt;

    logic                      r_accum_vld;
    logic [BRAM_AWIDTH-1:0]    r_vote_slot;
    logic                      r_done;

    // ------------------------------------------------------------------------
    // Clear length: product at full width, saturated to the address space
    // ------------------------------------------------------------------------
    assign w_samples_ext     = c_PROD_W'(r_n_samples);
    assign w_labels_ext      = c_PROD_W'(r_n_labels);
    assign w_prod            = r_is_clf ? (w_samples_ext * w_labels_ext) : w_samples_ext;
    assign w_clear_len       = (w_prod > c_CLEAR_MAX) ? {BRAM_AWIDTH{1'b1}}
                                                      : w_prod[BRAM_AWIDTH-1:0];
    assign w_clear_last_addr = w_clear_len - BRAM_AWIDTH'(1);
    assign w_clr_last        = (w_clear_len == '0) || (r_clr_addr == w_clear_last_addr);
    assign w_clear_we        = (r_state == S_CLEAR) && (w_clear_len != '0);

    // ------------------------------------------------------------------------
    // Admission: room left in the run, no label scan in flight, no RMW hazard
    // ------------------------------------------------------------------------
    assign w_acc_room  = (r_acc_cnt < r_n_results);
    assign w_scan_busy = (r_scan_cnt != '0);
    assign w_res_rdy   = (r_state == S_ACCUM) && w_acc_room && !w_scan_busy && !w_hazard;
    assign w_accept    = i_res_vld && w_res_rdy;

    // One comparator per in-flight write-back slot
    for (genvar g = 0; g < RMW_GAP; g++) begin : g_hazard
        assign w_match[g] = r_hist_vld[g] && (r_hist_slot[g] == i_res_slot);
    end

    assign w_hazard = |w_match;
    assign w_quiet  = !w_scan_busy && !(|r_hist_vld);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (w_clr_last) begin
                    w_next_state = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (r_acc_cnt == r_n_results) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_quiet && (r_drain_cnt == c_DRAIN_LAST)) begin
                    w_next_state = S_PS_READ;
                end
            end
            S_PS_READ: begin
                if (i_ps_read_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Run configuration is captured only when a start is honoured
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_clf    <= 1'b0;
            r_n_labels  <= '0;
            r_n_samples <= '0;
            r_n_results <= '0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_is_clf    <= i_is_clf;
            r_n_labels  <= i_n_labels;
            r_n_samples <= i_n_samples;
            r_n_results <= i_n_results;
        end
    end

    // Clear address walks 0..clear_len-1 and parks at the last address
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clr_addr <= '0;
        end else if (r_state == S_CLEAR) begin
            if (!w_clr_last) begin
                r_clr_addr <= r_clr_addr + BRAM_AWIDTH'(1);
            end
        end else begin
            r_clr_addr <= '0;
        end
    end

    // Accepted-result counter, restarted with each run; stops at n_results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc_cnt <= '0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_acc_cnt <= '0;
        end else if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + RESULTS_WIDTH'(1);
        end
    end

    // Label-scan guard: n_labels scan cycles plus the index-reset cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
        end else if (w_accept && r_is_clf) begin
            r_scan_cnt <= c_SCAN_W'(r_n_labels) + c_SCAN_W'(1);
        end else if (w_scan_busy) begin
            r_scan_cnt <= r_scan_cnt - c_SCAN_W'(1);
        end
    end

    // History of slots still travelling through the RMW pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hist_vld <= '0;
            for (int i = 0; i < RMW_GAP; i++) begin
                r_hist_slot[i] <= '0;
            end
        end else begin
            r_hist_vld[0]  <= w_accept;
            r_hist_slot[0] <= i_res_slot;
            for (int i = 1; i < RMW_GAP; i++) begin
                r_hist_vld[i]  <= r_hist_vld[i-1];
                r_hist_slot[i] <= r_hist_slot[i-1];
            end
        end
    end

    // Drain timer: counts quiet cycles, restarts if activity reappears
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drain_cnt <= '0;
        end else if (r_state != S_DRAIN) begin
            r_drain_cnt <= '0;
        end else if (!w_quiet) begin
            r_drain_cnt <= '0;
        end else if (r_drain_cnt != c_DRAIN_LAST) begin
            r_drain_cnt <= r_drain_cnt + c_DRAIN_W'(1);
        end
    end

    // Vote buffer handshake and completion pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_accum_vld <= 1'b0;
            r_vote_slot <= '0;
            r_done      <= 1'b0;
        end else begin
            r_accum_vld <= w_accept;
            if (w_accept) begin
                r_vote_slot <= i_res_slot;
            end
            r_done <= (r_state == S_DRAIN) && (w_next_state == S_PS_READ);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_res_rdy    = w_res_rdy;
    assign o_accum_vld  = r_accum_vld;
    assign o_vote_slot  = r_vote_slot;
    assign o_is_clf     = r_is_clf;
    assign o_n_labels   = r_n_labels;
    assign o_is_ps_read = (r_state == S_IDLE) || (r_state == S_CLEAR) || (r_state == S_PS_READ);
    assign o_clear_we   = w_clear_we;
    assign o_clear_addr = w_clear_we ? r_clr_addr : '0;
    assign o_clear_din  = '0;
    assign o_busy       = (r_state != S_IDLE) && (r_state != S_PS_READ);
    assign o_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vote_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vote_ctrl
// Purpose  : Self-checking bench for vote_ctrl. Each run is predicted from
//            cycle timestamps of accepts (clear length, spacing and hazard
//            windows, drain length) and compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vote_ctrl;

    localparam int RMW_GAP = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic        i_is_clf;
    logic [3:0]  i_n_labels;
    logic [13:0] i_n_samples;
    logic [19:0] i_n_results;
    logic        i_res_vld;
    logic [13:0] i_res_slot;
    logic        o_res_rdy;
    logic        o_accum_vld;
    logic [13:0] o_vote_slot;
    logic        o_is_clf;
    logic [3:0]  o_n_labels;
    logic        o_is_ps_read;
    logic        o_clear_we;
    logic [13:0] o_clear_addr;
    logic [15:0] o_clear_din;
    logic        i_ps_read_done;
    logic        o_busy;
    logic        o_done;

    int          n_vec = 0;
    int          n_err = 0;
    logic [13:0] exp_vote_slot = '0;
    int          slot_q[$];

    vote_ctrl #(
        .N_LABELS_WIDTH(4),
        .BRAM_AWIDTH   (14),
        .BRAM_DWIDTH   (16),
        .RESULTS_WIDTH (20),
        .RMW_GAP       (RMW_GAP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_is_clf      (i_is_clf),
        .i_n_labels    (i_n_labels),
        .i_n_samples   (i_n_samples),
        .i_n_results   (i_n_results),
        .i_res_vld     (i_res_vld),
        .i_res_slot    (i_res_slot),
        .o_res_rdy     (o_res_rdy),
        .o_accum_vld   (o_accum_vld),
        .o_vote_slot   (o_vote_slot),
        .o_is_clf      (o_is_clf),
        .o_n_labels    (o_n_labels),
        .o_is_ps_read  (o_is_ps_read),
        .o_clear_we    (o_clear_we),
        .o_clear_addr  (o_clear_addr),
        .o_clear_din   (o_clear_din),
        .i_ps_read_done(i_ps_read_done),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard time limit
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    // One complete run: start, clear, accumulate, drain, PS read, release.
    // abort_at >= 0 returns right after that many accepts (for reset tests).
    task automatic run_job(input bit clf, input int nl, input int ns, input int nr,
                           input int vld_pct, input int abort_at);
        int  len, L, c, acc, ta, t_drain, t_ps, q, idx, cur_slot, last_slot;
        bit  offering, exp_rdy, exp_avld;
        int  acc_cyc[$];
        int  acc_slot[$];

        len = clf ? ns * nl : ns;
        if (len > 16383) len = 16383;
        L = (len == 0) ? 1 : len;

        // Cycle 0: start in IDLE
        @(negedge clk);
        i_start = 1'b1; i_is_clf = clf; i_n_labels = 4'(nl);
        i_n_samples = 14'(ns); i_n_results = 20'(nr);
        i_res_vld = 1'($urandom); i_res_slot = 14'($urandom); i_ps_read_done = 1'b1;
        #1;
        n_vec++;
        if (o_busy !== 1'b0 || o_is_ps_read !== 1'b1 || o_res_rdy !== 1'b0 || o_clear_we !== 1'b0) begin
            n_err++;
            $display("FAIL idle_state: busy=%b ps_read=%b rdy=%b clear_we=%b, required 0 1 0 0",
                     o_busy, o_is_ps_read, o_res_rdy, o_clear_we);
        end

        // Clear phase, with noise on config, start and result inputs
        for (c = 1; c <= L; c++) begin
            @(negedge clk);
            i_start = 1'($urandom); i_is_clf = 1'($urandom); i_n_labels = 4'($urandom);
            i_n_samples = 14'($urandom); i_n_results = 20'($urandom);
            i_res_vld = 1'($urandom); i_res_slot = 14'($urandom); i_ps_read_done = 1'($urandom);
            #1;
            n_vec++;
            if (o_clear_we !== (len > 0) || (len > 0 && o_clear_addr !== 14'(c - 1)) ||
                o_clear_din !== 16'h0 || o_is_ps_read !== 1'b1 || o_busy !== 1'b1 ||
                o_res_rdy !== 1'b0 || o_done !== 1'b0) begin
                n_err++;
                $display("FAIL clear c=%0d: we=%b addr=%0d din=%0h ps_read=%b busy=%b rdy=%b done=%b, required we=%b addr=%0d din=0 ps_read=1 busy=1 rdy=0 done=0",
                         c, o_clear_we, o_clear_addr, o_clear_din, o_is_ps_read, o_busy, o_res_rdy, o_done,
                         (len > 0), c - 1);
            end
        end

        // Accumulation phase
        acc = 0; ta = -100; idx = 0; offering = 1'b0; cur_slot = 0; last_slot = 0;
        t_drain = -1; c = L + 1;
        while (t_drain < 0) begin
            @(negedge clk);
            i_start = 1'($urandom); i_ps_read_done = 1'($urandom);
            exp_avld = (ta == c - 1);
            if (exp_avld) exp_vote_slot = 14'(last_slot);
            exp_rdy = 1'b0;
            if (acc >= nr) begin
                t_drain = c + 1;
                i_res_vld = 1'($urandom); i_res_slot = 14'($urandom);
            end else begin
                if (!offering && $urandom_range(0, 99) < vld_pct) begin
                    offering = 1'b1;
                    cur_slot = (idx < slot_q.size()) ? slot_q[idx] : int'($urandom_range(0, 7));
                end
                i_res_vld  = offering;
                i_res_slot = offering ? 14'(cur_slot) : 14'($urandom_range(0, 7));
                exp_rdy = 1'b1;
                if (clf && ta >= 0 && (c - ta) < nl + 2) exp_rdy = 1'b0;
                foreach (acc_cyc[k])
                    if ((c - acc_cyc[k]) <= RMW_GAP && acc_slot[k] == int'(i_res_slot)) exp_rdy = 1'b0;
            end
            #1;
            n_vec++;
            if (o_res_rdy !== exp_rdy) begin
                n_err++;
                $display("FAIL res_rdy c=%0d slot=%0d: got %b, required %b", c, i_res_slot, o_res_rdy, exp_rdy);
            end
            if (o_accum_vld !== exp_avld || o_vote_slot !== exp_vote_slot) begin
                n_err++;
                $display("FAIL accum_pulse c=%0d: vld=%b slot=%0d, required vld=%b slot=%0d",
                         c, o_accum_vld, o_vote_slot, exp_avld, exp_vote_slot);
            end
            if (o_busy !== 1'b1 || o_is_ps_read !== 1'b0 || o_clear_we !== 1'b0 || o_done !== 1'b0 ||
                o_is_clf !== clf || o_n_labels !== 4'(nl)) begin
                n_err++;
                $display("FAIL accum_state c=%0d: busy=%b ps_read=%b we=%b done=%b is_clf=%b n_labels=%0d, required 1 0 0 0 %b %0d",
                         c, o_busy, o_is_ps_read, o_clear_we, o_done, o_is_clf, o_n_labels, clf, nl);
            end
            if (t_drain < 0 && offering && exp_rdy) begin
                acc_cyc.push_back(c);
                acc_slot.push_back(cur_slot);
                ta = c; last_slot = cur_slot; acc++; idx++; offering = 1'b0;
                if (abort_at >= 0 && acc == abort_at) begin
                    slot_q.delete();
                    return;
                end
            end
            c++;
            if (c - (L + 1) > 5000) begin
                n_err++;
                $display("FAIL accum_timeout: %0d of %0d accepts after 5000 cycles, required all", acc, nr);
                slot_q.delete();
                return;
            end
        end

        // Drain, ending with the completion pulse on PS_READ entry
        q = t_drain;
        if (nr > 0) begin
            if (ta + RMW_GAP + 1 > q) q = ta + RMW_GAP + 1;
            if (clf && ta + nl + 2 > q) q = ta + nl + 2;
        end
        t_ps = q + RMW_GAP;
        for (c = t_drain; c <= t_ps; c++) begin
            @(negedge clk);
            i_start = 1'($urandom); i_ps_read_done = 1'b0;
            i_res_vld = 1'($urandom); i_res_slot = 14'($urandom);
            exp_avld = (ta == c - 1);
            if (exp_avld) exp_vote_slot = 14'(last_slot);
            #1;
            n_vec++;
            if (o_done !== (c == t_ps) || o_busy !== (c != t_ps) || o_is_ps_read !== (c == t_ps) ||
                o_res_rdy !== 1'b0 || o_clear_we !== 1'b0 || o_accum_vld !== exp_avld ||
                o_vote_slot !== exp_vote_slot) begin
                n_err++;
                $display("FAIL drain c=%0d (ps_read at %0d): done=%b busy=%b ps_read=%b rdy=%b we=%b avld=%b, required done=%b busy=%b ps_read=%b rdy=0 we=0 avld=%b",
                         c, t_ps, o_done, o_busy, o_is_ps_read, o_res_rdy, o_clear_we, o_accum_vld,
                         (c == t_ps), (c != t_ps), (c == t_ps), exp_avld);
            end
        end

        // PS_READ ignores start, then leaves on read-done
        @(negedge clk);
        i_start = 1'b1; i_ps_read_done = 1'b0; i_res_vld = 1'b1;
        #1;
        n_vec++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_is_ps_read !== 1'b1 || o_res_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL ps_read_hold: done=%b busy=%b ps_read=%b rdy=%b, required 0 0 1 0",
                     o_done, o_busy, o_is_ps_read, o_res_rdy);
        end
        @(negedge clk);
        i_start = 1'b0; i_ps_read_done = 1'b1; i_res_vld = 1'b0;
        #1;
        n_vec++;
        if (o_busy !== 1'b0 || o_is_ps_read !== 1'b1 || o_clear_we !== 1'b0) begin
            n_err++;
            $display("FAIL ps_read_start_ignored: busy=%b ps_read=%b we=%b, required 0 1 0",
                     o_busy, o_is_ps_read, o_clear_we);
        end
        @(negedge clk);
        i_ps_read_done = 1'b0;
        #1;
        n_vec++;
        if (o_busy !== 1'b0 || o_is_ps_read !== 1'b1 || o_done !== 1'b0) begin
            n_err++;
            $display("FAIL back_to_idle: busy=%b ps_read=%b done=%b, required 0 1 0",
                     o_busy, o_is_ps_read, o_done);
        end
        slot_q.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; i_start = 1'b0; i_is_clf = 1'b0; i_n_labels = '0; i_n_samples = '0;
        i_n_results = '0; i_res_vld = 1'b0; i_res_slot = '0; i_ps_read_done = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (o_is_ps_read !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_res_rdy !== 1'b0 ||
            o_accum_vld !== 1'b0 || o_vote_slot !== 14'h0 || o_is_clf !== 1'b0 || o_n_labels !== 4'h0 ||
            o_clear_we !== 1'b0 || o_clear_addr !== 14'h0 || o_clear_din !== 16'h0) begin
            n_err++;
            $display("FAIL reset_values: ps_read=%b busy=%b done=%b rdy=%b avld=%b slot=%0d clf=%b nl=%0d we=%b addr=%0d, required ps_read=1 rest 0",
                     o_is_ps_read, o_busy, o_done, o_res_rdy, o_accum_vld, o_vote_slot, o_is_clf,
                     o_n_labels, o_clear_we, o_clear_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_regression_back_to_back;
        slot_q = '{0, 1, 2, 3};
        run_job(1'b0, 7, 4, 4, 100, -1);
    endtask

    task automatic test_classification_spacing;
        slot_q = '{0, 1};
        run_job(1'b1, 3, 2, 2, 100, -1);
    endtask

    task automatic test_hazard;
        slot_q = '{5, 5};
        run_job(1'b0, 0, 8, 2, 100, -1);
        slot_q = '{5, 6, 5};
        run_job(1'b0, 0, 8, 3, 100, -1);
    endtask

    task automatic test_empty_run;
        run_job(1'b0, 2, 0, 0, 100, -1);
        run_job(1'b1, 0, 9, 0, 100, -1);
    endtask

    task automatic test_clear_saturation;
        run_job(1'b1, 15, 16383, 2, 100, -1);
    endtask

    task automatic test_reset_mid_run;
        slot_q = '{1, 2, 3, 4};
        run_job(1'b0, 0, 4, 6, 100, 2);
        @(negedge clk);
        rst_n = 1'b0; i_start = 1'b0; i_res_vld = 1'b1; i_res_slot = 14'd3;
        @(negedge clk);
        rst_n = 1'b1;
        exp_vote_slot = '0;
        #1;
        n_vec++;
        if (o_busy !== 1'b0 || o_is_ps_read !== 1'b1 || o_res_rdy !== 1'b0 || o_accum_vld !== 1'b0 ||
            o_vote_slot !== 14'h0 || o_clear_we !== 1'b0 || o_done !== 1'b0) begin
            n_err++;
            $display("FAIL mid_run_reset: busy=%b ps_read=%b rdy=%b avld=%b slot=%0d we=%b done=%b, required 0 1 0 0 0 0 0",
                     o_busy, o_is_ps_read, o_res_rdy, o_accum_vld, o_vote_slot, o_clear_we, o_done);
        end
        i_res_vld = 1'b0;
        run_job(1'b0, 0, 4, 3, 100, -1);
    endtask

    task automatic test_random_runs;
        for (int r = 0; r < 8; r++) begin
            run_job(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 12)), int'($urandom_range(30, 100)), -1);
        end
    endtask

    initial begin
        test_reset;
        test_regression_back_to_back;
        test_classification_spacing;
        test_hazard;
        test_empty_run;
        test_clear_saturation;
        test_reset_mid_run;
        test_random_runs;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
